// File: rtl/mem_responder.sv
// mem_responder: on-chip RAM that answers the CPU's external memory requests.
// It adds WAIT_CYC wait states, pulses ready once per access and keeps a
// sticky error flag. A preload port fills the RAM while the CPU is stopped.
// Optional build macro: MEM_PARITY_EN adds an even-parity bit to each RAM
// word and a perr_inject test input that corrupts the next stored parity bit.
module mem_responder #(
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] memaddr,
    input  logic [7:0]  wdata,
    input  logic        read,
    input  logic        write,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic        err,
    output logic        busy,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data
`ifdef MEM_PARITY_EN
    ,
    input  logic        perr_inject
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE,
        HOLD
    } state_t;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [15:0]        r_addr;
    logic               r_isWrite;
    logic [7:0]         r_wdata;
    logic [7:0]         r_mem [DEPTH];

    logic               w_memOor;
    logic               w_ldOor;
    logic [ADDR_W-1:0]  w_memIdx;
    logic [ADDR_W-1:0]  w_ldIdx;
    logic               w_ldWe;
    logic               w_cpuWe;
    logic               w_memWe;
    logic [ADDR_W-1:0]  w_wrIdx;
    logic [7:0]         w_wrData;
    logic [7:0]         w_rdWord;

    // Any address bit at or above ADDR_W set means the access misses the RAM.
    assign w_memOor = (r_addr >> ADDR_W) != 16'd0;
    assign w_ldOor  = (ld_addr >> ADDR_W) != 16'd0;
    assign w_memIdx = r_addr[ADDR_W-1:0];
    assign w_ldIdx  = ld_addr[ADDR_W-1:0];

    // Preloads happen only in IDLE and CPU writes only in DONE, so the two
    // write sources never collide; reset blocks both.
    assign w_ldWe   = (r_state == IDLE) && ld_en && !w_ldOor;
    assign w_cpuWe  = (r_state == DONE) && r_isWrite && !w_memOor;
    assign w_memWe  = rst && (w_ldWe || w_cpuWe);
    assign w_wrIdx  = w_ldWe ? w_ldIdx : w_memIdx;
    assign w_wrData = w_ldWe ? ld_data : r_wdata;
    assign w_rdWord = r_mem[w_memIdx];

    assign busy = (r_state != IDLE);

`ifdef MEM_PARITY_EN
    logic               r_par [DEPTH];
    logic               r_injPend;
    logic               w_injFlip;
    logic               w_parBad;

    assign w_injFlip = r_injPend || perr_inject;
    assign w_parBad  = (^w_rdWord) != r_par[w_memIdx];
`endif

    // RAM storage: no reset, contents survive rst so preloaded programs stay.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[w_wrIdx] <= w_wrData;
`ifdef MEM_PARITY_EN
            r_par[w_wrIdx] <= (^w_wrData) ^ w_injFlip;
`endif
        end
    end

`ifdef MEM_PARITY_EN
    // Remember a parity-corruption request until the next RAM write uses it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_injPend <= 1'b0;
        end else if (w_memWe) begin
            r_injPend <= 1'b0;
        end else if (perr_inject) begin
            r_injPend <= 1'b1;
        end
    end
`endif

    // Access sequencer: latch the request, burn wait states, perform the
    // access in DONE (ready appears the cycle after), then hold until release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= 16'd0;
            r_isWrite <= 1'b0;
            r_wdata   <= 8'h00;
            rdata     <= 8'h00;
            ready     <= 1'b0;
            err       <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ld_en) begin
                        if (w_ldOor) begin
                            err <= 1'b1;
                        end
                    end else if (read && write) begin
                        err     <= 1'b1;
                        r_state <= HOLD;
                    end else if (read || write) begin
                        r_addr    <= memaddr;
                        r_isWrite <= write;
                        r_wdata   <= wdata;
                        r_cnt     <= WAIT_INIT;
                        r_state   <= (WAIT_CYC == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    ready   <= 1'b1;
                    r_state <= HOLD;
                    if (w_memOor) begin
                        err <= 1'b1;
                        if (!r_isWrite) begin
                            rdata <= 8'h00;
                        end
                    end else if (!r_isWrite) begin
                        rdata <= w_rdWord;
`ifdef MEM_PARITY_EN
                        if (w_parBad) begin
                            err <= 1'b1;
                        end
`endif
                    end
                end
                HOLD: begin
                    if (!read && !write) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
